// File: rtl/unary_decode.sv
// -----------------------------------------------------------------------------
// unary_decode
//
// Receive end of the comparator-based temporal encoder. Each lane carries a
// unary bitstream; over a fixed window of WIN = 2^INPUT_WIDTH cycles the block
// counts the ones seen on every lane. When the window closes, it presents all
// lane counts in parallel behind a valid/ready handshake.
//
// Configuration macro:
//   UNARY_DECODE_SAT_EN  - when defined, counts are INPUT_WIDTH bits wide and
//                          saturate at 2^INPUT_WIDTH-1. When undefined, counts
//                          are INPUT_WIDTH+1 bits wide and an all-ones window
//                          reads exactly WIN.
//
// Ports:
//   clk        in   1              clock
//   rst_n      in   1              asynchronous active-low reset
//   start      in   1              pulse that opens a window (IDLE, or DONE
//                                  together with a completed handshake)
//   clear      in   1              synchronous abort, overrides everything
//   in_bits    in   DIM_A          one unary bit per lane
//   out        out  DIM_A x CW     registered per-lane counts, lane i at out[i]
//   out_valid  out  1              result available (DONE state)
//   out_ready  in   1              consumer accepts the result
//   busy       out  1              window in progress (ACCUM state)
// -----------------------------------------------------------------------------
module unary_decode #(
   parameter int DIM_A       = 16,
   parameter int INPUT_WIDTH = 8,
`ifdef UNARY_DECODE_SAT_EN
   localparam int CW         = INPUT_WIDTH
`else
   localparam int CW         = INPUT_WIDTH + 1
`endif
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      clear,
   input  logic [DIM_A-1:0]          in_bits,
   output logic [DIM_A-1:0][CW-1:0]  out,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   state_t                     state;
   state_t                     state_next;

   logic [DIM_A-1:0][CW-1:0]   acc;
   logic [DIM_A-1:0][CW-1:0]   acc_sum;
   logic [INPUT_WIDTH-1:0]     wcnt;
   logic                       wcnt_last;

   logic                       zero_acc;
   logic                       accumulate;
   logic                       load_out;

   assign wcnt_last = (wcnt == {INPUT_WIDTH{1'b1}});
   assign busy      = (state == ACCUM);
   assign out_valid = (state == DONE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and datapath controls. clear is applied last so that it
   // overrides start, the handshake and the end-of-window transition.
   always_comb begin
      state_next = state;
      zero_acc   = 1'b0;
      accumulate = 1'b0;
      load_out   = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_next = ACCUM;
               zero_acc   = 1'b1;
            end
         end
         ACCUM: begin
            accumulate = 1'b1;
            if (wcnt_last) begin
               state_next = DONE;
               load_out   = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               if (start) begin
                  state_next = ACCUM;
                  zero_acc   = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (clear) begin
         state_next = IDLE;
         zero_acc   = 1'b1;
         accumulate = 1'b0;
         load_out   = 1'b0;
      end
   end

   // Per-lane add of this cycle's sample. The result also feeds the output
   // register on the final cycle, so the last sample lands in out directly.
   always_comb begin
      acc_sum = acc;
      for (int i = 0; i < DIM_A; i++) begin
`ifdef UNARY_DECODE_SAT_EN
         if (acc[i] == {CW{1'b1}}) begin
            acc_sum[i] = acc[i];
         end else begin
            acc_sum[i] = acc[i] + CW'(in_bits[i]);
         end
`else
         acc_sum[i] = acc[i] + CW'(in_bits[i]);
`endif
      end
   end

   // Accumulators, window counter and output register. out is only loaded on
   // the edge that enters DONE, so it holds through IDLE, clear and the next
   // window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         wcnt <= '0;
         out  <= '0;
      end else begin
         if (zero_acc) begin
            acc  <= '0;
            wcnt <= '0;
         end else if (accumulate) begin
            acc  <= acc_sum;
            wcnt <= wcnt + INPUT_WIDTH'(1);
         end
         if (load_out) begin
            out <= acc_sum;
         end
      end
   end

endmodule

// File: tb/tb_unary_decode.sv
// -----------------------------------------------------------------------------
// tb_unary_decode
//
// Self-checking bench for unary_decode with DIM_A=4, INPUT_WIDTH=4 (WIN=16).
// The reference model simply sums the bits driven on each lane during the
// WIN cycles following an accepted start, clamping to the count range when
// UNARY_DECODE_SAT_EN is defined.
// -----------------------------------------------------------------------------
module tb_unary_decode;

   localparam int DIM_A       = 4;
   localparam int INPUT_WIDTH = 4;
   localparam int WIN         = 1 << INPUT_WIDTH;
`ifdef UNARY_DECODE_SAT_EN
   localparam int CW          = INPUT_WIDTH;
`else
   localparam int CW          = INPUT_WIDTH + 1;
`endif
   localparam int MAX_COUNT   = (1 << CW) - 1;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      start;
   logic                      clear;
   logic [DIM_A-1:0]          in_bits;
   logic [DIM_A-1:0][CW-1:0]  out;
   logic                      out_valid;
   logic                      out_ready;
   logic                      busy;

   int                        checks   = 0;
   int                        failures = 0;
   int                        counts[DIM_A];
   logic [DIM_A*CW-1:0]       last_out;
   logic [DIM_A*CW-1:0]       pattern_exp;
   bit                        done;
   bit                        in_idle;

   unary_decode #(
      .DIM_A       (DIM_A),
      .INPUT_WIDTH (INPUT_WIDTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .clear     (clear),
      .in_bits   (in_bits),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   // Count one comparison and report it if the values differ.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected output word from the per-lane sums.
   function automatic logic [DIM_A*CW-1:0] expected_word(input int c[DIM_A]);
      logic [DIM_A*CW-1:0] w;
      int                  v;
      w = '0;
      for (int i = 0; i < DIM_A; i++) begin
         v = (c[i] > MAX_COUNT) ? MAX_COUNT : c[i];
         w[i*CW +: CW] = CW'(v);
      end
      return w;
   endfunction

   // Lane stimulus: 0 random, 1 directed pattern, 2 random with lane2 held high.
   function automatic logic [DIM_A-1:0] lane_bits(input int mode, input int k);
      logic [DIM_A-1:0] b;
      b = DIM_A'($urandom);
      if (mode == 1) begin
         b[0] = 1'b1;
         b[1] = 1'b0;
         b[2] = (k < 5);
         b[3] = ((k % 2) == 0);
      end else if (mode == 2) begin
         b[2] = 1'b1;
      end
      return b;
   endfunction

   task automatic startWindow();
      in_bits = DIM_A'($urandom);
      start   = 1'b1;
      tick();
      start   = 1'b0;
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      checkOutput("valid_after_start", 32'(out_valid), 32'd0);
   endtask

   // Drive one window after start has been accepted. Optional events (index
   // -1 disables): a stray start pulse, a clear, or an asynchronous reset.
   task automatic applyStimulus(input int mode, input int pulse_at,
                                input int clear_at, input int reset_at,
                                output bit window_done);
      logic [DIM_A-1:0] b;
      logic [DIM_A*CW-1:0] exp_word;
      window_done = 1'b0;
      for (int i = 0; i < DIM_A; i++) counts[i] = 0;
      for (int k = 0; k < WIN; k++) begin
         b       = lane_bits(mode, k);
         in_bits = b;
         start   = (k == pulse_at);
         clear   = (k == clear_at);
         checkOutput("busy_in_window", 32'(busy), 32'd1);
         if (k == 0) checkOutput("valid_in_window", 32'(out_valid), 32'd0);
         if (k == reset_at) begin
            #2;
            rst_n = 1'b0;
            #1;
            checkOutput("async_reset_out", 32'(out), 32'd0);
            checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
            checkOutput("async_reset_busy", 32'(busy), 32'd0);
            start = 1'b0;
            tick();
            rst_n    = 1'b1;
            last_out = '0;
            return;
         end
         tick();
         if (k == clear_at) begin
            clear = 1'b0;
            start = 1'b0;
            checkOutput("clear_busy", 32'(busy), 32'd0);
            checkOutput("clear_valid", 32'(out_valid), 32'd0);
            checkOutput("clear_out_kept", 32'(out), 32'(last_out));
            return;
         end
         for (int i = 0; i < DIM_A; i++) counts[i] += int'(b[i]);
      end
      start    = 1'b0;
      exp_word = expected_word(counts);
      checkOutput("valid_at_end", 32'(out_valid), 32'd1);
      checkOutput("busy_at_end", 32'(busy), 32'd0);
      checkOutput("counts", 32'(out), 32'(exp_word));
      last_out    = exp_word;
      window_done = 1'b1;
   endtask

   // Sit in DONE without out_ready; stray starts and in_bits must be ignored.
   task automatic holdDone(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         out_ready = 1'b0;
         start     = 1'($urandom_range(0, 1));
         in_bits   = DIM_A'($urandom);
         tick();
         checkOutput("hold_valid", 32'(out_valid), 32'd1);
         checkOutput("hold_out_stable", 32'(out), 32'(last_out));
      end
      start = 1'b0;
   endtask

   task automatic handshake(input bit with_start);
      out_ready = 1'b1;
      start     = with_start;
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
      checkOutput("hs_valid_drop", 32'(out_valid), 32'd0);
      checkOutput("hs_busy", 32'(busy), 32'(with_start));
      checkOutput("hs_out_kept", 32'(out), 32'(last_out));
   endtask

   task automatic idleCycles(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         start   = 1'b0;
         in_bits = DIM_A'($urandom);
         tick();
         checkOutput("idle_busy", 32'(busy), 32'd0);
         checkOutput("idle_valid", 32'(out_valid), 32'd0);
         checkOutput("idle_out_kept", 32'(out), 32'(last_out));
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b0;
      in_bits   = '0;
      last_out  = '0;

      // Reset state
      tick();
      checkOutput("reset_out", 32'(out), 32'd0);
      checkOutput("reset_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      idleCycles(5);

      // Directed pattern window: {16, 0, 5, 8}, lane0 saturating to 15
      pattern_exp = '0;
      pattern_exp[0*CW +: CW] = CW'((WIN > MAX_COUNT) ? MAX_COUNT : WIN);
      pattern_exp[1*CW +: CW] = CW'(0);
      pattern_exp[2*CW +: CW] = CW'(5);
      pattern_exp[3*CW +: CW] = CW'(8);
      startWindow();
      applyStimulus(1, -1, -1, -1, done);
      checkOutput("pattern_counts", 32'(out), 32'(pattern_exp));

      // Backpressure for 10 cycles, then release to IDLE
      holdDone(10);
      handshake(1'b0);
      idleCycles(2);

      // Back-to-back windows, second with lane2 constantly high
      startWindow();
      applyStimulus(0, -1, -1, -1, done);
      handshake(1'b1);
      applyStimulus(2, -1, -1, -1, done);
      checkOutput("b2b_lane2", 32'(out[2]), 32'((WIN > MAX_COUNT) ? MAX_COUNT : WIN));
      handshake(1'b0);

      // Stray start at wcnt=7
      startWindow();
      applyStimulus(0, 7, -1, -1, done);
      handshake(1'b0);

      // Clear at wcnt=9, then a fresh window
      startWindow();
      applyStimulus(0, -1, 9, -1, done);
      checkOutput("clear_no_result", 32'(done), 32'd0);
      idleCycles(3);
      startWindow();
      applyStimulus(0, -1, -1, -1, done);
      handshake(1'b0);

      // Asynchronous reset mid-window
      startWindow();
      applyStimulus(0, -1, -1, 6, done);
      idleCycles(4);
      startWindow();
      applyStimulus(0, -1, -1, -1, done);
      handshake(1'b0);

      // Randomized windows with random backpressure and exits from DONE
      in_idle = 1'b1;
      for (int w = 0; w < 12; w++) begin
         int choice;
         if (in_idle) startWindow();
         applyStimulus(0, -1, -1, -1, done);
         holdDone($urandom_range(0, 3));
         choice = $urandom_range(0, 2);
         if (choice == 0) begin
            handshake(1'b0);
            in_idle = 1'b1;
         end else if (choice == 1) begin
            handshake(1'b1);
            in_idle = 1'b0;
         end else begin
            clear     = 1'b1;
            out_ready = 1'b1;
            start     = 1'b1;
            tick();
            clear     = 1'b0;
            out_ready = 1'b0;
            start     = 1'b0;
            checkOutput("done_clear_valid", 32'(out_valid), 32'd0);
            checkOutput("done_clear_busy", 32'(busy), 32'd0);
            checkOutput("done_clear_out", 32'(out), 32'(last_out));
            in_idle = 1'b1;
         end
      end
      if (!in_idle) begin
         applyStimulus(0, -1, -1, -1, done);
         handshake(1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
